prime_sink: RTL



---
 rtl/prime_sink_if.sv | 25 ++
 rtl/prime_sink.sv | 61 ++++++
 2 files changed

// File: rtl/prime_sink_if.sv
// prime_sink_if: generator handshake, run control and show-ahead pop port of prime_sink.
interface prime_sink_if #(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = 2
);
  localparam int WIDTH = 1 << WIDTH_LOG;
  logic run;
  logic gen_go;
  logic gen_ready;
  logic gen_error;
  logic [WIDTH-1:0] gen_res;
  logic rd_en;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH_LOG:0] count;
  logic error;
  modport master (
    input  run, gen_ready, gen_error, gen_res, rd_en,
    output gen_go, out_valid, out_data, count, error
  );
  modport slave (
    output run, gen_ready, gen_error, gen_res, rd_en,
    input  gen_go, out_valid, out_data, count, error
  );
endinterface

// File: rtl/prime_sink.sv
// prime_sink: requests primes one at a time, buffers them in a circular FIFO and halts on generator faults.
module prime_sink #(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = 2
) (
  input logic clk,
  input logic rst,
  prime_sink_if.master bus
);
  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int DEPTH = 1 << DEPTH_LOG;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [DEPTH_LOG-1:0] wr_q, rd_q;
  logic [DEPTH_LOG:0] count_q, count_d;
  logic go_q, err_q, space, bad, push, pop;
  always_comb begin
    space = count_q < (DEPTH_LOG+1)'(DEPTH);
    bad = bus.gen_error || (bus.gen_ready && !(bus.gen_res > last_q));
    push = state_q == WAIT && !bad && bus.gen_ready;
    pop = bus.rd_en && count_q != '0;
    count_d = count_q + (DEPTH_LOG+1)'(push) - (DEPTH_LOG+1)'(pop);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.run && bus.gen_ready && !bus.gen_error && space ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = bad ? HALT : bus.gen_ready ? IDLE : WAIT;
      default: state_d = HALT;
    endcase
  end
  // last_q starts at 1 so the generator's post-reset res=1 can never be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      go_q <= 1'b0;
      err_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      last_q <= WIDTH'(1);
    end else begin
      state_q <= state_d;
      go_q <= state_d == ISSUE;
      err_q <= err_q | (state_q == WAIT && bad);
      count_q <= count_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (push) last_q <= bus.gen_res;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.gen_res;
  end
  assign bus.gen_go = go_q;
  assign bus.out_valid = count_q != '0;
  assign bus.out_data = mem_q[rd_q];
  assign bus.count = count_q;
  assign bus.error = err_q;
endmodule
